// File: rtl/dbus_req_skid_queue.sv
// Data-bus request queue between the pipeline and the DCache port: kseg0/kseg1 translation on entry,
// DEPTH-entry circular FIFO with optional zero-latency bypass when empty, synchronous flush.
module dbus_req_skid_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int BYPASS = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           up_valid,
  input  logic [31:0]                    up_addr,
  input  logic [2:0]                     up_size,
  input  logic [DATA_W/8-1:0]            up_strobe,
  input  logic [DATA_W-1:0]              up_data,
  output logic                           up_addr_ok,
  output logic                           down_valid,
  output logic [31:0]                    down_addr,
  output logic                           down_uncached,
  output logic [2:0]                     down_size,
  output logic [DATA_W/8-1:0]            down_strobe,
  output logic [DATA_W-1:0]              down_data,
  input  logic                           down_addr_ok,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int SW = DATA_W / 8;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic BYP = (BYPASS != 0);

  typedef struct packed {
    logic [31:0]       addr;
    logic              uncached;
    logic [2:0]        size;
    logic [SW-1:0]     strobe;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t          mem [DEPTH];
  req_t          up_req;
  req_t          head_req;
  req_t          down_req;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push;
  logic          pop;
  logic          bypass_hit;
  logic          wr_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // kseg0/kseg1 strip the top three bits; only kseg1 is uncached.
  always_comb begin
    up_req        = '0;
    up_req.size   = up_size;
    up_req.strobe = up_strobe;
    up_req.data   = up_data;
    if (up_addr[31:30] == 2'b10) begin
      up_req.addr     = {3'b000, up_addr[28:0]};
      up_req.uncached = up_addr[29];
    end else begin
      up_req.addr     = up_addr;
      up_req.uncached = 1'b0;
    end
  end

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign up_addr_ok = up_valid & ~full & ~flush & ~reset;
  assign down_valid = ~flush & ~reset & (~empty | (BYP & up_valid));
  assign push       = up_valid & up_addr_ok;
  assign pop        = down_valid & down_addr_ok & ~empty;
  assign bypass_hit = BYP & empty & up_valid & down_addr_ok & ~flush;
  assign wr_en      = push & ~bypass_hit;
  assign head_req   = mem[head];

  always_comb begin
    down_req = '0;
    if (down_valid) down_req = empty ? up_req : head_req;
  end

  assign down_addr     = down_req.addr;
  assign down_uncached = down_req.uncached;
  assign down_size     = down_req.size;
  assign down_strobe   = down_req.strobe;
  assign down_data     = down_req.data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) tail <= ptr_inc(tail);
      if (pop)   head <= ptr_inc(head);
      if (wr_en && !pop)      count <= count + CW'(1);
      else if (pop && !wr_en) count <= count - CW'(1);
    end
  end

  // Payload has no reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[tail] <= up_req;
  end

endmodule

// File: tb/tb_dbus_req_skid_queue.sv
// Directed bench for dbus_req_skid_queue: three instances (DEPTH2/bypass, DEPTH3/bypass, DEPTH2/no-bypass)
// share stimulus; each scenario inspects the instance it targets.
module tb_dbus_req_skid_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        up_valid = 1'b0;
  logic [31:0] up_addr = '0;
  logic [2:0]  up_size = '0;
  logic [3:0]  up_strobe = '0;
  logic [31:0] up_data = '0;
  logic        dok = 1'b0;

  logic        aok [3];
  logic        dv  [3];
  logic [31:0] daddr [3];
  logic        dunc [3];
  logic [2:0]  dsize [3];
  logic [3:0]  dstrb [3];
  logic [31:0] ddata [3];
  logic [1:0]  cnt [3];
  logic        fl  [3];
  logic        em  [3];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dbus_req_skid_queue #(.DATA_W(32), .DEPTH(2), .BYPASS(1)) u0 (
    .clk(clk), .reset(reset), .flush(flush), .up_valid(up_valid), .up_addr(up_addr),
    .up_size(up_size), .up_strobe(up_strobe), .up_data(up_data), .up_addr_ok(aok[0]),
    .down_valid(dv[0]), .down_addr(daddr[0]), .down_uncached(dunc[0]), .down_size(dsize[0]),
    .down_strobe(dstrb[0]), .down_data(ddata[0]), .down_addr_ok(dok), .count(cnt[0]),
    .full(fl[0]), .empty(em[0]));

  dbus_req_skid_queue #(.DATA_W(32), .DEPTH(3), .BYPASS(1)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .up_valid(up_valid), .up_addr(up_addr),
    .up_size(up_size), .up_strobe(up_strobe), .up_data(up_data), .up_addr_ok(aok[1]),
    .down_valid(dv[1]), .down_addr(daddr[1]), .down_uncached(dunc[1]), .down_size(dsize[1]),
    .down_strobe(dstrb[1]), .down_data(ddata[1]), .down_addr_ok(dok), .count(cnt[1]),
    .full(fl[1]), .empty(em[1]));

  dbus_req_skid_queue #(.DATA_W(32), .DEPTH(2), .BYPASS(0)) u2 (
    .clk(clk), .reset(reset), .flush(flush), .up_valid(up_valid), .up_addr(up_addr),
    .up_size(up_size), .up_strobe(up_strobe), .up_data(up_data), .up_addr_ok(aok[2]),
    .down_valid(dv[2]), .down_addr(daddr[2]), .down_uncached(dunc[2]), .down_size(dsize[2]),
    .down_strobe(dstrb[2]), .down_data(ddata[2]), .down_addr_ok(dok), .count(cnt[2]),
    .full(fl[2]), .empty(em[2]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    up_valid = 1'b0; flush = 1'b0; dok = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    up_valid = 1'b1; up_addr = 32'hA000_0040; dok = 1'b1;
    reset = 1'b1;
    tick();
    checks++; if (aok[0] !== 1'b0) begin fails++; $display("FAIL rst_addr_ok: got %b want 0", aok[0]); end
    checks++; if (dv[0] !== 1'b0) begin fails++; $display("FAIL rst_down_valid: got %b want 0", dv[0]); end
    checks++; if (daddr[0] !== 32'h0) begin fails++; $display("FAIL rst_down_addr: got %h want 0", daddr[0]); end
    checks++; if (cnt[0] !== 2'd0 || em[0] !== 1'b1 || fl[0] !== 1'b0) begin fails++; $display("FAIL rst_flags: count %0d empty %b full %b want 0 1 0", cnt[0], em[0], fl[0]); end
    do_reset();
  endtask

  task automatic test_bypass;
    do_reset();
    dok = 1'b1; up_valid = 1'b1; up_addr = 32'hA000_1000; up_size = 3'd2; up_strobe = 4'h0;
    #1;
    checks++; if (dv[0] !== 1'b1) begin fails++; $display("FAIL byp_valid: got %b want 1", dv[0]); end
    checks++; if (daddr[0] !== 32'h0000_1000) begin fails++; $display("FAIL byp_addr: got %h want 00001000", daddr[0]); end
    checks++; if (dunc[0] !== 1'b1) begin fails++; $display("FAIL byp_uncached: got %b want 1", dunc[0]); end
    checks++; if (aok[0] !== 1'b1) begin fails++; $display("FAIL byp_addr_ok: got %b want 1", aok[0]); end
    tick();
    up_valid = 1'b0;
    checks++; if (cnt[0] !== 2'd0) begin fails++; $display("FAIL byp_count: got %0d want 0", cnt[0]); end
  endtask

  task automatic test_fill_full;
    do_reset();
    dok = 1'b0; up_valid = 1'b1; up_addr = 32'h8000_0000;
    #1;
    checks++; if (aok[0] !== 1'b1) begin fails++; $display("FAIL full_acc0: got %b want 1", aok[0]); end
    tick();
    up_addr = 32'h8000_0004;
    #1;
    checks++; if (aok[0] !== 1'b1) begin fails++; $display("FAIL full_acc1: got %b want 1", aok[0]); end
    tick();
    up_addr = 32'h8000_0008;
    #1;
    checks++; if (cnt[0] !== 2'd2 || fl[0] !== 1'b1) begin fails++; $display("FAIL full_flag: count %0d full %b want 2 1", cnt[0], fl[0]); end
    checks++; if (aok[0] !== 1'b0) begin fails++; $display("FAIL full_reject: got %b want 0", aok[0]); end
    checks++; if (daddr[0] !== 32'h0 || dunc[0] !== 1'b0) begin fails++; $display("FAIL full_head0: addr %h unc %b want 00000000 0", daddr[0], dunc[0]); end
    dok = 1'b1;
    #1;
    checks++; if (aok[0] !== 1'b0) begin fails++; $display("FAIL full_no_fallthrough: got %b want 0", aok[0]); end
    tick();
    checks++; if (daddr[0] !== 32'h0000_0004) begin fails++; $display("FAIL full_head1: got %h want 00000004", daddr[0]); end
    checks++; if (aok[0] !== 1'b1) begin fails++; $display("FAIL full_reopen: got %b want 1", aok[0]); end
    tick();
    up_valid = 1'b0;
    #1;
    checks++; if (cnt[0] !== 2'd1 || daddr[0] !== 32'h0000_0008) begin fails++; $display("FAIL full_third: count %0d addr %h want 1 00000008", cnt[0], daddr[0]); end
    tick();
    checks++; if (cnt[0] !== 2'd0 || dv[0] !== 1'b0) begin fails++; $display("FAIL full_drain: count %0d valid %b want 0 0", cnt[0], dv[0]); end
  endtask

  task automatic test_wrap;
    do_reset();
    dok = 1'b0; up_valid = 1'b1; up_addr = 32'h0000_0100;
    tick();
    checks++; if (cnt[1] !== 2'd1) begin fails++; $display("FAIL wrap_prefill: got %0d want 1", cnt[1]); end
    dok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      up_addr = 32'h0000_0104 + 32'(4 * i);
      #1;
      checks++; if (daddr[1] !== 32'h0000_0100 + 32'(4 * i) || aok[1] !== 1'b1) begin fails++; $display("FAIL wrap_order%0d: addr %h ok %b want %h 1", i, daddr[1], aok[1], 32'h0000_0100 + 32'(4 * i)); end
      tick();
      checks++; if (cnt[1] !== 2'd1) begin fails++; $display("FAIL wrap_count%0d: got %0d want 1", i, cnt[1]); end
    end
    up_valid = 1'b0;
    #1;
    checks++; if (daddr[1] !== 32'h0000_0114) begin fails++; $display("FAIL wrap_last: got %h want 00000114", daddr[1]); end
    tick();
    checks++; if (cnt[1] !== 2'd0) begin fails++; $display("FAIL wrap_drain: got %0d want 0", cnt[1]); end
  endtask

  task automatic test_no_bypass;
    do_reset();
    dok = 1'b1; up_valid = 1'b1; up_addr = 32'h1234_5678; up_strobe = 4'hF; up_data = 32'hDEAD_BEEF; up_size = 3'd2;
    #1;
    checks++; if (dv[2] !== 1'b0 || aok[2] !== 1'b1) begin fails++; $display("FAIL nobyp_same_cycle: valid %b ok %b want 0 1", dv[2], aok[2]); end
    tick();
    up_valid = 1'b0; up_strobe = 4'h0; up_data = 32'h0;
    #1;
    checks++; if (dv[2] !== 1'b1 || daddr[2] !== 32'h1234_5678 || dunc[2] !== 1'b0) begin fails++; $display("FAIL nobyp_out: valid %b addr %h unc %b want 1 12345678 0", dv[2], daddr[2], dunc[2]); end
    checks++; if (dstrb[2] !== 4'hF || ddata[2] !== 32'hDEAD_BEEF || dsize[2] !== 3'd2) begin fails++; $display("FAIL nobyp_payload: strb %h data %h size %0d want f deadbeef 2", dstrb[2], ddata[2], dsize[2]); end
    tick();
    checks++; if (cnt[2] !== 2'd0 || dv[2] !== 1'b0) begin fails++; $display("FAIL nobyp_drain: count %0d valid %b want 0 0", cnt[2], dv[2]); end
  endtask

  task automatic test_flush;
    do_reset();
    dok = 1'b0; up_valid = 1'b1; up_addr = 32'hA000_0010;
    tick();
    up_addr = 32'hA000_0014;
    tick();
    checks++; if (cnt[0] !== 2'd2 || dunc[0] !== 1'b1 || daddr[0] !== 32'h0000_0010) begin fails++; $display("FAIL flush_pre: count %0d unc %b addr %h want 2 1 00000010", cnt[0], dunc[0], daddr[0]); end
    flush = 1'b1; up_addr = 32'h0000_0020;
    #1;
    checks++; if (aok[0] !== 1'b0 || dv[0] !== 1'b0 || daddr[0] !== 32'h0) begin fails++; $display("FAIL flush_cycle: ok %b valid %b addr %h want 0 0 0", aok[0], dv[0], daddr[0]); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (cnt[0] !== 2'd0 || em[0] !== 1'b1 || aok[0] !== 1'b1) begin fails++; $display("FAIL flush_after: count %0d empty %b ok %b want 0 1 1", cnt[0], em[0], aok[0]); end
    tick();
    checks++; if (cnt[0] !== 2'd1 || daddr[0] !== 32'h0000_0020) begin fails++; $display("FAIL flush_new: count %0d addr %h want 1 00000020", cnt[0], daddr[0]); end
  endtask

  task automatic test_reset_mid;
    up_addr = 32'h0000_0030;
    tick();
    up_valid = 1'b0;
    #1;
    checks++; if (cnt[0] !== 2'd2) begin fails++; $display("FAIL rmid_pre: got %0d want 2", cnt[0]); end
    #2;
    up_valid = 1'b1;
    reset = 1'b1;
    #1;
    checks++; if (dv[0] !== 1'b0 || daddr[0] !== 32'h0 || aok[0] !== 1'b0) begin fails++; $display("FAIL rmid_out: valid %b addr %h ok %b want 0 0 0", dv[0], daddr[0], aok[0]); end
    checks++; if (cnt[0] !== 2'd0 || em[0] !== 1'b1 || fl[0] !== 1'b0) begin fails++; $display("FAIL rmid_flags: count %0d empty %b full %b want 0 1 0", cnt[0], em[0], fl[0]); end
    up_valid = 1'b0;
    tick();
    reset = 1'b0;
    dok = 1'b1;
    tick();
    checks++; if (dv[0] !== 1'b0 || daddr[0] !== 32'h0 || cnt[0] !== 2'd0) begin fails++; $display("FAIL rmid_after: valid %b addr %h count %0d want 0 0 0", dv[0], daddr[0], cnt[0]); end
  endtask

  initial begin
    tick();
    test_reset();
    test_bypass();
    test_fill_full();
    test_wrap();
    test_no_bypass();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dbus_req_skid_queue.md
Name: dbus_req_skid_queue

Overview:
- Parametrised successor to the single-entry data-bus request skid register in the MMU request path.
- Sits between the pipeline's dbus request and the DCache request port.
- Performs fixed kseg0/kseg1 address translation and tags uncached requests.
- Holds up to DEPTH requests in strict FIFO order, with optional zero-latency bypass when empty and a synchronous flush.

Parameters:
DATA_W, 32, width of write data; strobe width is DATA_W/8
DEPTH, 2, number of buffered requests; any integer >= 1, not restricted to powers of two
BYPASS, 1, 1 = an empty queue forwards the upstream request combinationally; 0 = every request is registered first (1-cycle minimum latency)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous discard of all queued requests
up_valid  input  1  upstream request valid
up_addr  input  32  virtual address
up_size  input  3  access size code, passed through unchanged
up_strobe  input  DATA_W/8  byte write strobes; all-zero means read
up_data  input  DATA_W  write data
up_addr_ok  output  1  upstream request accepted this cycle
down_valid  output  1  request presented to DCache
down_addr  output  32  physical address
down_uncached  output  1  request targets kseg1
down_size  output  3  passed size code
down_strobe  output  DATA_W/8  passed strobes
down_data  output  DATA_W  passed data
down_addr_ok  input  1  DCache accepted the presented request
count  output  $clog2(DEPTH+1)  number of occupied entries
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Translation is combinational and applied on entry to the queue or bypass path, never on exit.
  - vaddr[31:29] = 3'b100: paddr = {3'b000, vaddr[28:0]}, uncached = 0.
  - vaddr[31:29] = 3'b101: paddr = {3'b000, vaddr[28:0]}, uncached = 1.
  - Any other value: paddr = vaddr, uncached = 0.
- Storage is circular, with head and tail pointers wrapping at DEPTH-1 → 0. count is a separate up/down counter, not derived from the pointers.
- up_addr_ok = up_valid & !full & !flush & !reset.
  - Depends only on registered count, so no full-through in the same cycle: when full, a pop does not free a slot until the next cycle.
- down_valid = !flush & (!empty | (BYPASS & up_valid)).
- down_* fields:
  - head entry when !empty;
  - translated upstream fields when empty and BYPASS = 1;
  - all zero when down_valid = 0.
- push = up_valid & up_addr_ok.
- pop = down_valid & down_addr_ok & !empty.
- bypass_hit = BYPASS & empty & up_valid & down_addr_ok & !flush.
  - The request passes straight through with no write and no count change.
  - If empty, BYPASS = 1 and down_addr_ok = 0, the request is pushed and presented from the head entry next cycle.
- Counter rules:
  - push without bypass_hit, no pop: write at tail, tail++, count++.
  - pop without push: head++, count--.
  - push and pop together: both pointers advance, count unchanged.
- flush (synchronous):
  - Next cycle head = tail = 0 and count = 0.
  - In the flush cycle up_addr_ok = 0 and down_valid = 0; no request is accepted or forwarded.
- Reset (asynchronous):
  - head = tail = count = 0.
  - Outputs while reset is high: up_addr_ok = 0, down_valid = 0, down_* = 0, empty = 1, full = 0.
  - Reset mid-stream drops all queued entries with no partial output.
- Entry payload contents are don't-care on reset; only the pointers and count are reset.
- Ordering: DCache sees requests in exactly upstream acceptance order; no reordering between reads and writes.

Test Plan:
- BYPASS = 1, empty, down_addr_ok = 1, up_addr = 0xA000_1000:
  - same-cycle down_valid = 1, down_addr = 0x0000_1000, down_uncached = 1, count stays 0.
- DEPTH = 2, down_addr_ok held 0, three back-to-back requests 0x8000_0000/4/8:
  - first two accepted; count = 2, full = 1; third gets up_addr_ok = 0.
  - After releasing down_addr_ok: outputs 0x0000_0000 then 0x0000_0004; up_addr_ok returns 1 one cycle after the first pop.
- DEPTH = 3, count = 1, simultaneous push and pop for 5 cycles:
  - count stays 1; pointers wrap; output address order matches input order exactly.
- BYPASS = 0, empty, up_addr = 0x1234_5678 with strobe 4'b1111:
  - down_valid rises next cycle with down_addr = 0x1234_5678, down_uncached = 0, data and strobe intact.
- count = 2, assert flush one cycle with up_valid = 1:
  - in that cycle up_addr_ok = 0 and down_valid = 0; next cycle count = 0, empty = 1, and the new request is accepted normally.
- Assert reset asynchronously mid-cycle with count = 2:
  - outputs go to reset values immediately; after deassertion count = 0 and no stale request appears on down_*.
